// File: rtl/gcd_sequencer.sv
// Operand FIFO plus dispatcher/collector around a GCD engine: zero operands bypass the
// engine, and a watchdog turns a missing gcd_done into an error result.
module gcd_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         gcd_a,
  output logic [WIDTH-1:0]         gcd_b,
  output logic                     gcd_start,
  input  logic [WIDTH-1:0]         gcd_result,
  input  logic                     gcd_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q, count_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [WIDTH-1:0]   gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
  logic               gcd_start_q, gcd_start_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic               out_err_q, out_err_d;

  logic               push, pop, slot_free, load, load_err;
  logic [WIDTH-1:0]   head_a, head_b, load_res;

  assign in_ready   = reset_n && (count_q != FULL);
  assign gcd_a      = gcd_a_q;
  assign gcd_b      = gcd_b_q;
  assign gcd_start  = gcd_start_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;
  assign count      = count_q;

  always_comb begin
    push         = in_valid && in_ready;
    slot_free    = !out_valid_q || out_ready;
    head_a       = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
    head_b       = mem_q[rd_ptr_q][WIDTH-1:0];
    state_d      = state_q;
    timer_d      = timer_q;
    gcd_a_d      = gcd_a_q;
    gcd_b_d      = gcd_b_q;
    gcd_start_d  = 1'b0;
    pop          = 1'b0;
    load         = 1'b0;
    load_err     = 1'b0;
    load_res     = '0;

    case (state_q)
      IDLE: begin
        if (count_q != '0 && slot_free) begin
          pop = 1'b1;
          // gcd(0,x)=x and gcd(0,0)=0, so OR-ing the operands is the answer
          if (head_a == '0 || head_b == '0) begin
            load     = 1'b1;
            load_res = head_a | head_b;
          end else begin
            gcd_a_d     = head_a;
            gcd_b_d     = head_b;
            gcd_start_d = 1'b1;
            timer_d     = '0;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (gcd_done) begin
          load     = 1'b1;
          load_res = gcd_result;
          state_d  = IDLE;
        end else if (timer_q == TLAST) begin
          load     = 1'b1;
          load_err = 1'b1;
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Dispatch only happens with a free slot, so a load never overwrites an unaccepted result.
    if (load)                          out_valid_d = 1'b1;
    else if (out_valid_q && out_ready) out_valid_d = 1'b0;
    else                               out_valid_d = out_valid_q;
    out_result_d = load ? load_res : out_result_q;
    out_err_d    = load ? load_err : out_err_q;
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      gcd_a_q      <= '0;
      gcd_b_q      <= '0;
      gcd_start_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_d;
      timer_q      <= timer_d;
      gcd_a_q      <= gcd_a_d;
      gcd_b_q      <= gcd_b_d;
      gcd_start_q  <= gcd_start_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
    end
  end
endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: behavioural engine, reference gcd and in-order result scoreboard.
module tb_gcd_sequencer;
  localparam int W = 32;
  localparam int D = 4;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b, gcd_a, gcd_b, gcd_result, out_result;
  logic         gcd_start, gcd_done, out_valid, out_err;
  logic         out_ready = 1'b0;
  logic [$clog2(D):0] count;

  logic         eng_done = 1'b0, late_done;
  logic [W-1:0] eng_res = '0, late_res;
  logic         hang_mode, rnd_ready, ready_fix;
  int           lat_lo, lat_hi, exp_lat;
  int           errors = 0, checks = 0, cyc = 0;
  logic         busy = 1'b0;

  typedef struct { logic [W-1:0] res; logic err; int acc; } exp_t;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
  exp_t  exp_q[$];
  pair_t disp_q[$];

  assign gcd_done   = eng_done | late_done;
  assign gcd_result = late_done ? late_res : eng_res;

  gcd_sequencer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .gcd_a(gcd_a), .gcd_b(gcd_b), .gcd_start(gcd_start),
    .gcd_result(gcd_result), .gcd_done(gcd_done), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_err(out_err), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine: answers lat_lo..lat_hi cycles after a start, or never in hang mode.
  initial begin
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (reset_n && gcd_start && !hang_mode) begin
        logic [W-1:0] a, b;
        int lat;
        a = gcd_a;
        b = gcd_b;
        lat = int'($urandom_range(lat_hi, lat_lo));
        repeat (lat) @(negedge clk);
        eng_res  = ref_gcd(a, b);
        eng_done = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : ready_fix;
    end
  end

  // Monitor: records pushes, checks dispatches and accepted results in order.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      disp_q.delete();
      busy = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("out_extra", W'(out_valid), 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("out_result", out_result, e.res);
          check_eq("out_err", W'(out_err), W'(e.err));
          if (e.acc != 0) check_eq("out_latency", cyc, e.acc);
        end
      end
      if (gcd_start) begin
        check_eq("start_while_busy", W'(busy), 0);
        busy = 1'b1;
        if (disp_q.size() == 0) check_eq("start_extra", W'(gcd_start), 0);
        else begin
          pair_t p;
          p = disp_q.pop_front();
          check_eq("gcd_a", gcd_a, p.a);
          check_eq("gcd_b", gcd_b, p.b);
        end
      end
      if (eng_done) busy = 1'b0;
      if (out_valid && out_err) busy = 1'b0;
      if (in_valid && in_ready) begin
        exp_t e;
        e.acc = (exp_lat != 0) ? cyc + exp_lat : 0;
        if (in_a == 0 || in_b == 0) begin
          e.res = in_a | in_b;
          e.err = 1'b0;
        end else begin
          e.res = hang_mode ? '0 : ref_gcd(in_a, in_b);
          e.err = hang_mode;
          disp_q.push_back('{a: in_a, b: in_b});
        end
        exp_q.push_back(e);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that took the pair.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    logic ok = 1'b0;
    in_a = a;
    in_b = b;
    exp_lat = lat;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check_eq("push_timeout", W'(ok), 1);
  endtask

  task automatic drain(input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0);
    end
    check_eq("drain_complete", W'(done), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation ran past its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic any_ov, any_start;
    in_valid = 0; in_a = 0; in_b = 0; exp_lat = 0;
    hang_mode = 0; rnd_ready = 0; ready_fix = 1;
    lat_lo = 4; lat_hi = 4; late_done = 0; late_res = 0;

    #12;
    check_eq("rst_in_ready", W'(in_ready), 0);
    check_eq("rst_count", W'(count), 0);
    check_eq("rst_out_valid", W'(out_valid), 0);
    check_eq("rst_gcd_start", W'(gcd_start), 0);
    check_eq("rst_out_result", out_result, 0);
    check_eq("rst_out_err", W'(out_err), 0);
    check_eq("rst_gcd_a", gcd_a, 0);
    check_eq("rst_gcd_b", gcd_b, 0);
    @(posedge clk); #1;
    reset_n = 1;
    @(posedge clk); #1;
    check_eq("post_rst_in_ready", W'(in_ready), 1);

    // Single dispatch, engine answers 4 cycles after start.
    push(48, 18, 7);
    drain(100);
    check_eq("gcd_a_held", gcd_a, 48);
    check_eq("gcd_b_held", gcd_b, 18);

    // Zero-operand bypasses.
    push(0, 7, 2);
    push(0, 0, 2);
    push(9, 0, 2);
    drain(100);

    // Output backpressure fills the FIFO and stalls the sixth pair.
    lat_lo = 3; lat_hi = 3; ready_fix = 0;
    push(12, 18, 0);
    push(100, 75, 0);
    push(7, 49, 0);
    push(36, 24, 0);
    push(81, 27, 0);
    fork
      push(35, 14, 0);
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("bp_count_full", W'(count), 4);
        check_eq("bp_in_ready", W'(in_ready), 0);
        check_eq("bp_out_valid", W'(out_valid), 1);
        check_eq("bp_out_held", out_result, 6);
        @(posedge clk); #1;
        ready_fix = 1;
      end
    join
    drain(300);

    // Hung engine: watchdog errors, then the next queued pair dispatches.
    hang_mode = 1;
    push(5, 3, 2 + T);
    push(12, 8, 2 * T + 2);
    drain(200);

    // Reset while waiting with two pairs queued, then a stray late done.
    push(20, 10, 0);
    push(30, 6, 0);
    push(8, 4, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_count", W'(count), 2);
    @(posedge clk); #1;
    reset_n = 0;
    #2;
    check_eq("mid_rst_count", W'(count), 0);
    check_eq("mid_rst_in_ready", W'(in_ready), 0);
    check_eq("mid_rst_out_valid", W'(out_valid), 0);
    check_eq("mid_rst_gcd_a", gcd_a, 0);
    check_eq("mid_rst_gcd_b", gcd_b, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    hang_mode = 0;
    late_res = 77;
    late_done = 1;
    @(posedge clk); #1;
    late_done = 0;
    any_ov = 0;
    any_start = 0;
    repeat (12) begin
      @(negedge clk);
      any_ov = any_ov | out_valid;
      any_start = any_start | gcd_start;
    end
    check_eq("after_rst_no_out", W'(any_ov), 0);
    check_eq("after_rst_no_start", W'(any_start), 0);
    check_eq("after_rst_count", W'(count), 0);
    check_eq("after_rst_in_ready", W'(in_ready), 1);
    check_eq("after_rst_out_result", out_result, 0);
    @(posedge clk); #1;

    // Random stream with random consumer and engine latency.
    lat_lo = 1; lat_hi = 10; rnd_ready = 1;
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] f, x, y;
      f = W'($urandom_range(50, 1));
      x = W'($urandom_range(300, 1));
      y = W'($urandom_range(300, 1));
      push(f * x, f * y, 0);
    end
    drain(3000);
    rnd_ready = 0;
    check_eq("final_count", W'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gcd_sequencer.md
# gcd_sequencer

Operand sequencer that sits directly upstream of the GCD engine and also collects its results. It buffers operand pairs from a valid/ready stream in a small FIFO and dispatches one pair at a time to the engine with a single-cycle start pulse. It captures the engine's result on done and presents it on a valid/ready output stream. Zero operands bypass the engine, and a watchdog converts a hung engine into an error result.

## Interface
- WIDTH, 32, operand/result width
- DEPTH, 4, FIFO entries; power of two, ≥2
- TIMEOUT, 1024, max cycles from gcd_start to gcd_done; ≥2
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept; equals count<DEPTH
- in_a, in_b  in  WIDTH  operand pair
- gcd_a, gcd_b  out  WIDTH  operands to engine, registered
- gcd_start  out  1  one-cycle dispatch pulse to engine
- gcd_result  in  WIDTH  engine result, valid when gcd_done=1
- gcd_done  in  1  engine completion pulse
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  GCD result
- out_err  out  1  result produced by watchdog timeout
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FIFO:
  - A push happens when in_valid && in_ready.
  - A pop happens on dispatch or bypass.
  - Simultaneous push and pop leaves count unchanged.
  - There is no write-through: a pair pushed at edge N is visible at the head from cycle N+1.
  - Pointers wrap modulo DEPTH.
- Output slot free = !out_valid || out_ready.
- The slot is cleared when out_valid && out_ready, unless it is reloaded on the same edge.
- FSM states: IDLE, WAIT.
- IDLE, FIFO non-empty, slot free, and head a==0 or b==0 (bypass):
  - out_result <= a|b (gcd(0,x)=x, gcd(0,0)=0)
  - out_err <= 0, out_valid <= 1
  - pop; stay in IDLE
- IDLE, FIFO non-empty, slot free, both operands nonzero (dispatch):
  - gcd_a <= a, gcd_b <= b, gcd_start <= 1
  - pop; clear timer; go to WAIT
- gcd_start is high for exactly one cycle.
- gcd_a and gcd_b hold their values until the next dispatch.
- WAIT, gcd_done=1:
  - out_result <= gcd_result, out_err <= 0, out_valid <= 1
  - go to IDLE
- WAIT, no done, timer==TIMEOUT-1:
  - out_result <= 0, out_err <= 1, out_valid <= 1
  - go to IDLE
- WAIT, otherwise: timer increments.
- In WAIT the slot is always free, because dispatch required a free slot and the slot is not refilled while waiting.
- gcd_done in IDLE is ignored.
- gcd_done in the same cycle the timer expires counts as done (no error).
- Only one operation is in flight at a time; results leave in FIFO order.
- Reset asynchronously clears:
  - FIFO pointers and count
  - the FSM, to IDLE
  - the timer
  - gcd_start, gcd_a, gcd_b, out_valid, out_result, out_err
- While reset_n is low, in_ready=0, count=0, and every other output is 0.
- A reset in the middle of an operation discards the in-flight pair and all buffered pairs.

## Timing
- Push at edge N means the pair is at the head in cycle N+1.
- Bypass path: out_valid is high from cycle N+2 when the slot is free, i.e. two cycles of latency.
- Dispatch path:
  - gcd_start is high in cycle N+2.
  - If the engine asserts gcd_done in cycle N+2+L, out_valid rises in cycle N+3+L.
- Timeout: with gcd_start in cycle S, out_err/out_valid rise in cycle S+TIMEOUT.
- out_valid, out_result and out_err stay stable until they are accepted.
- Back-to-back operation:
  - A dispatch may occur in the same cycle the previous result is accepted.
  - With the engine result held, the next gcd_start can follow one cycle after the output loads.
- in_ready is not combinationally dependent on out_ready or on a pop.

## Test plan
- Push (48,18), out_ready=1, model engine asserts done with result 6 four cycles after start -> gcd_start pulses once with gcd_a=48, gcd_b=18; out_result=6, out_err=0, out_valid one cycle after done.
- Push (0,7), then (0,0), then (9,0) -> results 7, 0, 9 in that order with no gcd_start; each is valid two cycles after its push when the slot is free.
- DEPTH=4, out_ready=0, engine done 3 cycles after start, push 6 nonzero pairs -> first result held in out_*; count reaches 4, in_ready=0, the 6th pair stalls until out_ready=1.
- TIMEOUT=16, engine never asserts done, push (5,3) -> out_valid and out_err=1, out_result=0 exactly 16 cycles after gcd_start; the next queued pair then dispatches.
- Assert reset_n low in WAIT with 2 pairs queued; late gcd_done after release -> all outputs 0, count=0, in_ready=1, no out_valid produced.
- Stream 20 random nonzero pairs, random out_ready, engine latency 1-10 cycles -> results match the reference gcd, in order, none dropped or duplicated, gcd_start never asserted while in WAIT.
